// File: rtl/mem_cache_pkg.sv
// mem_cache_pkg
//   Shared definitions for the write-through word cache:
//   - state_t        : controller states
//   - DEF_IDX_BITS   : default log2 of the line count
//   - addr_index()   : line index field of a byte address
//   - addr_tag()     : tag field of a byte address
package mem_cache_pkg;

    localparam int DEF_IDX_BITS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT
    } state_t;

    // Index sits just above the byte offset; callers truncate to IDX_BITS.
    function automatic logic [31:0] addr_index(input logic [31:0] a, input int idx_bits);
        return (a >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    // Everything above the index; callers truncate to TAG_BITS.
    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int idx_bits);
        return a >> (idx_bits + 2);
    endfunction

endpackage

// File: rtl/mem_wt_cache_array.sv
// mem_wt_cache_array
//   Valid/tag/data storage for a direct-mapped, one-word-per-line cache.
//   Ports:
//     clk, rst          : clock, asynchronous active-low reset (clears valid bits)
//     clear             : bulk invalidate of every line
//     lk_idx, lk_tag    : combinational lookup address
//     lk_hit, lk_data   : lookup result (data is the raw line contents)
//     we, wr_idx,
//     wr_tag, wr_data   : single write port; a write also marks the line valid
module mem_wt_cache_array #(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [IDX_BITS-1:0] lk_idx,
    input  logic [TAG_BITS-1:0] lk_tag,
    output logic                lk_hit,
    output logic [31:0]         lk_data,
    input  logic                we,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_data
);

    localparam int LINES = 1 << IDX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags  [LINES];
    logic [31:0]         words [LINES];

    // Only the valid bits need reset; tag/data are meaningless until valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx]  <= wr_tag;
            words[wr_idx] <= wr_data;
        end
    end

    assign lk_hit  = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    assign lk_data = words[lk_idx];

endmodule

// File: rtl/mem_wt_cache.sv
// mem_wt_cache
//   Direct-mapped, write-through, no-write-allocate word cache. Upstream and
//   downstream use the same request/busy/ack handshake, so the cache can be
//   placed between a load/store unit and memory without either side changing.
//   Ports:
//     clk, rst                 : clock, asynchronous active-low reset
//     rd_req, wr_req, addr,
//     wr_data                  : CPU request (write wins), sampled while busy=0
//     busy, ack, rd_data       : CPU response; rd_data is 0 except during ack
//     inv                      : invalidate all lines (honoured only when idle)
//     mem_rd_req, mem_wr_req,
//     mem_addr, mem_wr_data    : one-cycle request pulses to memory
//     mem_busy, mem_ack,
//     mem_rd_data              : memory response
//     hit_count, miss_count    : read hit / read miss counters (wrap)
module mem_wt_cache
    import mem_cache_pkg::*;
#(
    parameter int IDX_BITS = DEF_IDX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rd_data,
    input  logic        inv,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic        mem_busy,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAG_BITS = 30 - IDX_BITS;

    state_t state;

    // Word address and write data of the transaction in flight.
    logic [29:0] lat_word;
    logic [31:0] lat_data;

    logic [IDX_BITS-1:0] req_idx, lat_idx, arr_idx;
    logic [TAG_BITS-1:0] req_tag, lat_tag, arr_tag;
    logic [31:0]         arr_wdata;
    logic                arr_we;
    logic                lk_hit;
    logic [31:0]         lk_data;

    logic idle, clear, take_wr, take_rd, fill;

    assign req_idx = IDX_BITS'(addr_index(addr, IDX_BITS));
    assign req_tag = TAG_BITS'(addr_tag(addr, IDX_BITS));
    assign lat_idx = IDX_BITS'(addr_index({lat_word, 2'b00}, IDX_BITS));
    assign lat_tag = TAG_BITS'(addr_tag({lat_word, 2'b00}, IDX_BITS));

    // inv takes priority over any request in the same cycle; write beats read.
    assign idle    = (state == S_IDLE);
    assign clear   = idle && inv;
    assign take_wr = idle && !inv && wr_req;
    assign take_rd = idle && !inv && !wr_req && rd_req;
    assign fill    = (state == S_RD_WAIT) && mem_ack;

    // The single write port serves both the write-hit update (current
    // request) and the miss fill (latched address).
    always_comb begin
        arr_we    = 1'b0;
        arr_idx   = req_idx;
        arr_tag   = req_tag;
        arr_wdata = wr_data;
        if (take_wr && lk_hit) begin
            arr_we = 1'b1;
        end else if (fill) begin
            arr_we    = 1'b1;
            arr_idx   = lat_idx;
            arr_tag   = lat_tag;
            arr_wdata = mem_rd_data;
        end
    end

    mem_wt_cache_array #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .lk_idx  (req_idx),
        .lk_tag  (req_tag),
        .lk_hit  (lk_hit),
        .lk_data (lk_data),
        .we      (arr_we),
        .wr_idx  (arr_idx),
        .wr_tag  (arr_tag),
        .wr_data (arr_wdata)
    );

    always_ff @(posedge clk) begin
        if (take_wr) begin
            lat_word <= addr[31:2];
            lat_data <= wr_data;
        end else if (take_rd && !lk_hit) begin
            lat_word <= addr[31:2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            ack         <= 1'b0;
            rd_data     <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            // ack, rd_data and the memory requests are single-cycle pulses.
            ack        <= 1'b0;
            rd_data    <= '0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take_wr) begin
                        busy  <= 1'b1;
                        state <= S_WR_ISSUE;
                    end else if (take_rd) begin
                        if (lk_hit) begin
                            ack       <= 1'b1;
                            rd_data   <= lk_data;
                            hit_count <= hit_count + 32'd1;
                        end else begin
                            miss_count <= miss_count + 32'd1;
                            busy       <= 1'b1;
                            state      <= S_RD_ISSUE;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (!mem_busy) begin
                        mem_rd_req <= 1'b1;
                        mem_addr   <= {lat_word, 2'b00};
                        state      <= S_RD_WAIT;
                    end
                end
                S_WR_ISSUE: begin
                    if (!mem_busy) begin
                        mem_wr_req  <= 1'b1;
                        mem_addr    <= {lat_word, 2'b00};
                        mem_wr_data <= lat_data;
                        state       <= S_WR_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_ack) begin
                        ack     <= 1'b1;
                        rd_data <= mem_rd_data;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_WR_WAIT: begin
                    if (mem_ack) begin
                        ack   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wt_cache.sv
// tb_mem_wt_cache
//   Bench for mem_wt_cache: a 6-cycle memory model with an out-of-band write
//   port, directed scenarios, and a randomized stream checked against a
//   behavioural model (line index -> cached word address and data).
module tb_mem_wt_cache;

    localparam int LINES = 16;
    localparam int MISS_LAT = 8;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req = 1'b0, wr_req = 1'b0, inv = 1'b0;
    logic [31:0] addr = '0, wr_data = '0;
    logic        busy, ack;
    logic [31:0] rd_data;
    logic        mem_rd_req, mem_wr_req;
    logic [31:0] mem_addr, mem_wr_data;
    logic        mem_busy, mem_ack;
    logic [31:0] mem_rd_data;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wt_cache dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .ack         (ack),
        .rd_data     (rd_data),
        .inv         (inv),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_busy    (mem_busy),
        .mem_ack     (mem_ack),
        .mem_rd_data (mem_rd_data),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    // Memory model: 256 words; mem_ack rises 6 cycles after the request pulse.
    logic [31:0] mem [256];
    logic        oob_we = 1'b0;
    logic [7:0]  oob_idx = '0;
    logic [31:0] oob_data = '0;
    int          cnt;
    logic        pend_rd;
    logic [7:0]  pend_idx;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    logic [31:0] last_maddr = '0, last_mwdata = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_busy    <= 1'b0;
            mem_ack     <= 1'b0;
            mem_rd_data <= '0;
            cnt         <= 0;
        end else begin
            mem_ack     <= 1'b0;
            mem_rd_data <= '0;
            if (oob_we) mem[oob_idx] <= oob_data;
            if (mem_rd_req) rd_pulses <= rd_pulses + 1;
            if (mem_wr_req) wr_pulses <= wr_pulses + 1;
            if (mem_rd_req || mem_wr_req) begin
                last_maddr  <= mem_addr;
                last_mwdata <= mem_wr_data;
            end
            if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    mem_ack  <= 1'b1;
                    mem_busy <= 1'b0;
                    if (pend_rd) mem_rd_data <= mem[pend_idx];
                end
            end else if (mem_rd_req || mem_wr_req) begin
                mem_busy <= 1'b1;
                cnt      <= 5;
                pend_rd  <= mem_rd_req;
                pend_idx <= mem_addr[9:2];
                if (mem_wr_req) mem[mem_addr[9:2]] <= mem_wr_data;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [256];
    logic [29:0] m_word [int];
    logic [31:0] m_data [int];
    logic [31:0] m_hits = '0, m_misses = '0;

    task automatic model_read(input logic [31:0] a, output logic hit, output logic [31:0] d);
        logic [29:0] w;
        int i;
        w = a[31:2];
        i = int'(w % LINES);
        if (m_word.exists(i) && m_word[i] == w) begin
            hit = 1'b1;
            d = m_data[i];
            m_hits = m_hits + 1;
        end else begin
            hit = 1'b0;
            d = ref_mem[w[7:0]];
            m_word[i] = w;
            m_data[i] = d;
            m_misses = m_misses + 1;
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        logic [29:0] w;
        int i;
        w = a[31:2];
        i = int'(w % LINES);
        ref_mem[w[7:0]] = d;
        if (m_word.exists(i) && m_word[i] == w) m_data[i] = d;
    endtask

    task automatic model_clear_lines();
        m_word.delete();
        m_data.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic oob_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        oob_we = 1'b1;
        oob_idx = a[9:2];
        oob_data = d;
        @(negedge clk);
        oob_we = 1'b0;
        ref_mem[a[9:2]] = d;
    endtask

    task automatic pulse_inv();
        @(negedge clk);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        model_clear_lines();
    endtask

    // lat = edges after the accepting edge until ack is visible (hit: 0).
    task automatic cpu_op(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdat, output int lat);
        @(negedge clk);
        wr_req = w;
        rd_req = r;
        addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        lat = 0;
        while (ack !== 1'b1 && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdat = rd_data;
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout addr=%h got no ack within %0d cycles", a, TMO);
        end
    endtask

    task automatic run_read(input logic [31:0] a, output logic [31:0] rdat, output int lat,
                            output logic eh, output logic [31:0] ed);
        model_read(a, eh, ed);
        cpu_op(1'b0, 1'b1, a, 32'h0, rdat, lat);
    endtask

    task automatic run_write(input logic [31:0] a, input logic [31:0] d, output int lat);
        logic [31:0] dummy;
        model_write(a, d);
        cpu_op(1'b1, 1'b0, a, d, dummy, lat);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, ack, mem_rd_req, mem_wr_req} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {busy, ack, mem_rd_req, mem_wr_req});
        end
        checks++;
        if ({rd_data, mem_addr, mem_wr_data} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h want zeros", rd_data, mem_addr, mem_wr_data);
        end
        checks++;
        if ({hit_count, miss_count} !== 64'b0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count, miss_count);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) oob_write(32'(i) << 2, $urandom);
    endtask

    task automatic test_miss_hit();
        logic [31:0] rdat, ed;
        logic eh;
        int lat, rp;
        oob_write(32'h40, 32'hDEADBEEF);
        rp = rd_pulses;
        run_read(32'h40, rdat, lat, eh, ed);
        checks++;
        if (rdat !== 32'hDEADBEEF || lat != MISS_LAT) begin
            errors++;
            $display("FAIL miss_read got %h lat %0d want deadbeef lat %0d", rdat, lat, MISS_LAT);
        end
        checks++;
        if (rd_pulses - rp != 1 || last_maddr !== 32'h40) begin
            errors++;
            $display("FAIL miss_memreq got %0d pulses addr %h want 1 pulse addr 00000040", rd_pulses - rp, last_maddr);
        end
        checks++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL miss_counts got h%0d m%0d want h0 m1", hit_count, miss_count);
        end
        rp = rd_pulses;
        run_read(32'h40, rdat, lat, eh, ed);
        checks++;
        if (rdat !== 32'hDEADBEEF || lat != 0 || rd_pulses != rp) begin
            errors++;
            $display("FAIL hit_read got %h lat %0d memreqs %0d want deadbeef lat 0 memreqs 0", rdat, lat, rd_pulses - rp);
        end
        checks++;
        if (hit_count !== 32'd1) begin
            errors++;
            $display("FAIL hit_count got %0d want 1", hit_count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL ack_pulse got ack %b rd_data %h want 0 0", ack, rd_data);
        end
    endtask

    task automatic test_write_through();
        logic [31:0] rdat, ed;
        logic eh;
        int lat, wp;
        wp = wr_pulses;
        run_write(32'h40, 32'h12345678, lat);
        checks++;
        if (wr_pulses - wp != 1 || last_maddr !== 32'h40 || last_mwdata !== 32'h12345678 || lat != MISS_LAT) begin
            errors++;
            $display("FAIL wt_write got %0d pulses %h/%h lat %0d want 1 00000040/12345678 lat %0d",
                     wr_pulses - wp, last_maddr, last_mwdata, lat, MISS_LAT);
        end
        run_read(32'h40, rdat, lat, eh, ed);
        checks++;
        if (rdat !== 32'h12345678 || lat != 0) begin
            errors++;
            $display("FAIL wt_reread got %h lat %0d want 12345678 lat 0", rdat, lat);
        end
    endtask

    task automatic test_no_allocate();
        logic [31:0] rdat, ed, d;
        logic eh;
        int lat;
        d = $urandom;
        run_write(32'h80, d, lat);
        run_read(32'h80, rdat, lat, eh, ed);
        checks++;
        if (lat != MISS_LAT || miss_count !== 32'd2 || rdat !== d) begin
            errors++;
            $display("FAIL no_alloc got lat %0d misses %0d data %h want lat %0d misses 2 data %h",
                     lat, miss_count, rdat, MISS_LAT, d);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] rdat, ed, m0;
        logic eh;
        int lat;
        logic [31:0] seq [3];
        seq[0] = 32'h04;
        seq[1] = 32'h44;
        seq[2] = 32'h04;
        m0 = miss_count;
        for (int k = 0; k < 3; k++) begin
            run_read(seq[k], rdat, lat, eh, ed);
            checks++;
            if (lat != MISS_LAT || rdat !== ref_mem[seq[k][9:2]]) begin
                errors++;
                $display("FAIL conflict_%0d got lat %0d data %h want lat %0d data %h",
                         k, lat, rdat, MISS_LAT, ref_mem[seq[k][9:2]]);
            end
        end
        checks++;
        if (miss_count - m0 !== 32'd3) begin
            errors++;
            $display("FAIL conflict_misses got %0d want 3", miss_count - m0);
        end
    endtask

    task automatic test_invalidate();
        logic [31:0] rdat, ed, old_v, new_v;
        logic eh;
        int lat;
        run_read(32'h40, rdat, lat, eh, ed);
        old_v = rdat;
        new_v = ~old_v;
        oob_write(32'h40, new_v);
        // Without invalidation the stale line still hits.
        run_read(32'h40, rdat, lat, eh, ed);
        checks++;
        if (rdat !== old_v || lat != 0) begin
            errors++;
            $display("FAIL inv_stale got %h lat %0d want %h lat 0", rdat, lat, old_v);
        end
        pulse_inv();
        run_read(32'h40, rdat, lat, eh, ed);
        checks++;
        if (rdat !== new_v || lat != MISS_LAT) begin
            errors++;
            $display("FAIL inv_refetch got %h lat %0d want %h lat %0d", rdat, lat, new_v, MISS_LAT);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rdat, ed;
        logic eh;
        int lat, acks;
        run_read(32'hC8, rdat, lat, eh, ed);
        @(negedge clk);
        rd_req = 1'b1;
        addr = 32'h88;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, ack, mem_rd_req, mem_wr_req} !== 4'b0 || {hit_count, miss_count} !== 64'b0) begin
            errors++;
            $display("FAIL midreset got ctrl %b counts %0d/%0d want 0000 0/0",
                     {busy, ack, mem_rd_req, mem_wr_req}, hit_count, miss_count);
        end
        model_clear_lines();
        m_hits = '0;
        m_misses = '0;
        acks = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) acks++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL midreset_ack got %0d acks want 0", acks);
        end
        run_read(32'hC8, rdat, lat, eh, ed);
        checks++;
        if (lat != MISS_LAT || miss_count !== 32'd1 || rdat !== ref_mem[8'h32]) begin
            errors++;
            $display("FAIL postreset_read got lat %0d misses %0d data %h want lat %0d misses 1 data %h",
                     lat, miss_count, rdat, MISS_LAT, ref_mem[8'h32]);
        end
    endtask

    task automatic test_contention();
        logic [31:0] rdat, ed, d, h0, m0;
        logic eh;
        int lat, rp, wp;
        d = $urandom;
        rp = rd_pulses;
        wp = wr_pulses;
        h0 = hit_count;
        m0 = miss_count;
        model_write(32'h30, d);
        cpu_op(1'b1, 1'b1, 32'h30, d, rdat, lat);
        checks++;
        if (wr_pulses - wp != 1 || rd_pulses != rp || hit_count !== h0 || miss_count !== m0) begin
            errors++;
            $display("FAIL both_req got wr %0d rd %0d dh %0d dm %0d want wr 1 rd 0 dh 0 dm 0",
                     wr_pulses - wp, rd_pulses - rp, hit_count - h0, miss_count - m0);
        end
        run_read(32'h30, rdat, lat, eh, ed);
        checks++;
        if (rdat !== d) begin
            errors++;
            $display("FAIL both_req_data got %h want %h", rdat, d);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] rdat, ed, m0;
        logic eh;
        int lat, rp;
        rp = rd_pulses;
        m0 = miss_count;
        model_write(32'h20, 32'hA5A5_0F0F);
        @(negedge clk);
        wr_req = 1'b1;
        addr = 32'h20;
        wr_data = 32'hA5A5_0F0F;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        @(negedge clk);
        rd_req = 1'b1;
        addr = 32'h24;
        @(negedge clk);
        rd_req = 1'b0;
        lat = 0;
        while (ack !== 1'b1 && lat < TMO) begin
            @(posedge clk);
            #1;
            lat++;
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (rd_pulses != rp || miss_count !== m0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore got rd %0d dm %0d busy %b want 0 0 0", rd_pulses - rp, miss_count - m0, busy);
        end
        run_read(32'h24, rdat, lat, eh, ed);
        checks++;
        if (lat != MISS_LAT || rdat !== ed) begin
            errors++;
            $display("FAIL busy_ignore_read got lat %0d data %h want lat %0d data %h", lat, rdat, MISS_LAT, ed);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int unsigned sel;
            logic [31:0] a, d, rdat, ed;
            logic eh;
            int lat, rp, wp;
            sel = $urandom_range(0, 99);
            a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            rp = rd_pulses;
            wp = wr_pulses;
            if (sel < 60) begin
                run_read(a, rdat, lat, eh, ed);
                checks++;
                if (rdat !== ed || lat != (eh ? 0 : MISS_LAT) || rd_pulses - rp != (eh ? 0 : 1)) begin
                    errors++;
                    $display("FAIL rnd_read[%0d] addr %h got %h lat %0d memrd %0d want %h lat %0d memrd %0d",
                             n, a, rdat, lat, rd_pulses - rp, ed, eh ? 0 : MISS_LAT, eh ? 0 : 1);
                end
                checks++;
                if (hit_count !== m_hits || miss_count !== m_misses) begin
                    errors++;
                    $display("FAIL rnd_counts[%0d] got h%0d m%0d want h%0d m%0d",
                             n, hit_count, miss_count, m_hits, m_misses);
                end
            end else if (sel < 90) begin
                run_write(a, d, lat);
                checks++;
                if (lat != MISS_LAT || wr_pulses - wp != 1 || last_mwdata !== d || last_maddr !== {a[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL rnd_write[%0d] got lat %0d pulses %0d %h/%h want lat %0d pulses 1 %h/%h",
                             n, lat, wr_pulses - wp, last_maddr, last_mwdata, MISS_LAT, {a[31:2], 2'b00}, d);
                end
            end else if (sel < 95) begin
                pulse_inv();
            end else begin
                oob_write(a, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_write_through();
        test_no_allocate();
        test_conflict();
        test_invalidate();
        test_reset_midflight();
        test_contention();
        test_busy_ignore();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
